// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared register offsets, CTRL bit positions and default width for the PWM peripheral
package pwm_pkg;

  localparam int DEFAULT_CNT_W = 16;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_DUTY   = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

  localparam int EN       = 0;
  localparam int WRAP_STS = 8;
  localparam int IRQ_MASK = 9;

endpackage

// File: rtl/pwm_core.sv
// rtl/pwm_core.sv - PWM counter, active period/duty registers, compare and wrap pulse
module pwm_core
  import pwm_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] per_s,
  input  logic [CNT_W-1:0] duty_s,
  output logic [CNT_W-1:0] cnt,
  output logic             pwm_out,
  output logic             wrap
);

  logic             en_d;
  logic             rise;
  logic [CNT_W-1:0] per_a;
  logic [CNT_W-1:0] duty_a;

  assign rise = en & ~en_d;
  // A wrap needs the counter to have been running already; the enable cycle itself only loads.
  assign wrap = en & en_d & (cnt == per_a);

  // Counter, active-register load and registered compare; the enable cycle is a pure load cycle
  // with the output held low so the first period starts cleanly from cnt = 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_d    <= 1'b0;
      cnt     <= '0;
      per_a   <= '0;
      duty_a  <= '0;
      pwm_out <= 1'b0;
    end else begin
      en_d <= en;
      if (!en) begin
        cnt     <= '0;
        pwm_out <= 1'b0;
      end else if (rise) begin
        per_a   <= per_s;
        duty_a  <= duty_s;
        cnt     <= '0;
        pwm_out <= 1'b0;
      end else begin
        pwm_out <= (cnt < duty_a);
        if (wrap) begin
          cnt    <= '0;
          per_a  <= per_s;
          duty_a <= duty_s;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pwm_periph.sv
// rtl/pwm_periph.sv - PWM bus slave: register file, read mux, optional wrap interrupt (PWM_IRQ_EN)
module pwm_periph
  import pwm_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bSel,
  input  logic [3:0]  bAddr,
  input  logic        bWr,
  input  logic        bRd,
  input  logic [31:0] bWData,
  output logic [31:0] bRData,
  output logic        pwm_out,
  output logic        irq
);

  logic             wr;
  logic             rd;
  logic [1:0]       reg_sel;
  logic             ctrl_en;
  logic [CNT_W-1:0] per_s;
  logic [CNT_W-1:0] duty_s;
  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic             sts_q;
  logic             mask_q;
  logic [31:0]      rd_mux;
  logic             unused_bits;

  assign wr      = bSel & bWr;
  assign rd      = bSel & bRd;
  assign reg_sel = bAddr[3:2];

  // Byte-lane bits of the address and write-data bits outside the fields carry no meaning.
  assign unused_bits = ^{bAddr[1:0], bWData, wrap};

  function automatic logic [31:0] zext(input logic [CNT_W-1:0] v);
    zext = '0;
    zext[CNT_W-1:0] = v;
  endfunction

  // Writable registers: EN and the period/duty shadows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_en <= 1'b0;
      per_s   <= '0;
      duty_s  <= '0;
    end else if (wr) begin
      case (reg_sel)
        REG_CTRL:   ctrl_en <= bWData[EN];
        REG_PERIOD: per_s   <= bWData[CNT_W-1:0];
        REG_DUTY:   duty_s  <= bWData[CNT_W-1:0];
        default:    ;
      endcase
    end
  end

`ifdef PWM_IRQ_EN
  // Sticky wrap status and its mask; a wrap in the same cycle as a clear keeps the status set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sts_q  <= 1'b0;
      mask_q <= 1'b0;
    end else begin
      if (wr && reg_sel == REG_CTRL) begin
        mask_q <= bWData[IRQ_MASK];
      end
      if (wrap) begin
        sts_q <= 1'b1;
      end else if (wr && reg_sel == REG_CTRL && bWData[WRAP_STS]) begin
        sts_q <= 1'b0;
      end
    end
  end

  assign irq = sts_q & mask_q;
`else
  assign sts_q  = 1'b0;
  assign mask_q = 1'b0;
  assign irq    = 1'b0;
`endif

  // Read mux over the pre-write register values; shadows are what PERIOD/DUTY return.
  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      REG_CTRL: begin
        rd_mux[EN]       = ctrl_en;
        rd_mux[WRAP_STS] = sts_q;
        rd_mux[IRQ_MASK] = mask_q;
      end
      REG_PERIOD: rd_mux = zext(per_s);
      REG_DUTY:   rd_mux = zext(duty_s);
      default:    rd_mux = zext(cnt);
    endcase
  end

  // Registered read data, zero whenever no read is strobed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bRData <= '0;
    end else begin
      bRData <= rd ? rd_mux : '0;
    end
  end

  pwm_core #(
    .CNT_W(CNT_W)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .en     (ctrl_en),
    .per_s  (per_s),
    .duty_s (duty_s),
    .cnt    (cnt),
    .pwm_out(pwm_out),
    .wrap   (wrap)
  );

endmodule

// File: tb/tb_pwm_periph.sv
// tb/tb_pwm_periph.sv - self-checking bench for pwm_periph against an arithmetic period model
module tb_pwm_periph;

  localparam logic [3:0] A_CTRL = 4'h0;
  localparam logic [3:0] A_PER  = 4'h4;
  localparam logic [3:0] A_DUTY = 4'h8;
  localparam logic [3:0] A_CNT  = 4'hC;

  logic        clk = 1'b0;
  logic        rst;
  logic        bSel;
  logic [3:0]  bAddr;
  logic        bWr;
  logic        bRd;
  logic [31:0] bWData;
  logic [31:0] bRData;
  logic        pwm_out;
  logic        irq;

  int checks = 0;
  int errors = 0;

  pwm_periph #(
    .CNT_W(16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bSel   (bSel),
    .bAddr  (bAddr),
    .bWr    (bWr),
    .bRd    (bRd),
    .bWData (bWData),
    .bRData (bRData),
    .pwm_out(pwm_out),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive, let one rising edge pass, sample point is 1 time unit after it.
  task automatic cycle(input logic sel, input logic wr, input logic rd,
                       input logic [3:0] a, input logic [31:0] d);
    bSel   = sel;
    bWr    = wr;
    bRd    = rd;
    bAddr  = a;
    bWData = d;
    @(posedge clk);
    #1;
    bSel = 1'b0;
    bWr  = 1'b0;
    bRd  = 1'b0;
  endtask

  // Model: edge k=0 writes EN=1, edge 1 loads the shadows, and from then on the counter value
  // after edge j is (j-1) mod (P+1). Period n begins at load edge 1+n*(P+1) and uses the duty
  // shadow value present just before that edge; pwm_out lags the compare by one edge.
  task automatic run_cfg(input int p, input int d, input int wk, input int d2, input int n);
    int pos;
    int nper;
    int dn;
    logic ep;
    cycle(1'b1, 1'b1, 1'b0, A_CTRL, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, A_PER, p);
    cycle(1'b1, 1'b1, 1'b0, A_DUTY, d);
    cycle(1'b1, 1'b0, 1'b1, A_PER | 4'h3, 32'h0);
    chk("period_shadow_read", bRData, p);
    cycle(1'b1, 1'b0, 1'b1, A_DUTY, 32'h0);
    chk("duty_shadow_read", bRData, d);
    cycle(1'b1, 1'b1, 1'b0, A_CTRL, 32'h1);
    for (int k = 1; k <= n; k++) begin
      if (k == wk) cycle(1'b1, 1'b1, 1'b0, A_DUTY, d2);
      else         cycle(1'b1, 1'b0, 1'b1, A_CNT, 32'h0);
      pos = 0;
      ep  = 1'b0;
      if (k > 1) begin
        pos  = (k - 2) % (p + 1);
        nper = (k - 2) / (p + 1);
        dn   = (wk != 0 && 1 + nper * (p + 1) > wk) ? d2 : d;
        ep   = (pos < dn);
      end
      chk("pwm_out", 32'(pwm_out), 32'(ep));
      if (k != wk) chk("count_read", bRData, pos);
      chk("irq_masked", 32'(irq), 32'h0);
    end
  endtask

  initial begin
    int p;
    int d;
    int wk;
    int d2;
    logic sts;
    logic w;
    rst    = 1'b1;
    bSel   = 1'b0;
    bWr    = 1'b0;
    bRd    = 1'b0;
    bAddr  = 4'h0;
    bWData = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pwm", 32'(pwm_out), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    chk("reset_rdata", bRData, 32'h0);
    #3 rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 4'(i * 4), 32'h0);
      chk("reset_reg_read", bRData, 32'h0);
      chk("reset_pwm_idle", 32'(pwm_out), 32'h0);
    end
    cycle(1'b0, 1'b0, 1'b0, A_CTRL, 32'h0);
    chk("rdata_idle", bRData, 32'h0);

    // Basic 3-high / 7-low waveform, then bus edge cases while still running (k continues).
    run_cfg(9, 3, 0, 0, 25);
    cycle(1'b0, 1'b1, 1'b0, A_PER, 32'h55);
    cycle(1'b1, 1'b0, 1'b1, A_PER, 32'h0);
    chk("unselected_write_ignored", bRData, 32'd9);
    cycle(1'b1, 1'b1, 1'b0, A_CNT, 32'h3);
    for (int k = 29; k <= 32; k++) begin
      cycle(1'b1, 1'b0, 1'b1, A_CNT, 32'h0);
      chk("count_write_ignored", bRData, (k - 2) % 10);
      chk("pwm_after_count_write", 32'(pwm_out), 32'(((k - 2) % 10) < 3));
    end
    cycle(1'b1, 1'b1, 1'b0, A_CTRL, 32'h0);
    chk("pwm_high_at_disable", 32'(pwm_out), 32'h1);
    cycle(1'b1, 1'b0, 1'b1, A_CNT, 32'h0);
    chk("pwm_low_after_disable", 32'(pwm_out), 32'h0);
    chk("count_at_disable", bRData, 32'd2);
    cycle(1'b1, 1'b0, 1'b1, A_CNT, 32'h0);
    chk("count_held_zero", bRData, 32'd0);
    cycle(1'b1, 1'b1, 1'b1, A_PER, 32'h5);
    chk("rd_wr_same_cycle_old", bRData, 32'd9);
    cycle(1'b1, 1'b0, 1'b1, A_PER, 32'h0);
    chk("rd_wr_same_cycle_new", bRData, 32'd5);
    cycle(1'b1, 1'b1, 1'b0, A_PER, 32'hFFFF_0007);
    cycle(1'b1, 1'b0, 1'b1, A_PER, 32'h0);
    chk("period_upper_bits_dropped", bRData, 32'd7);

    // Duty change mid-period, then constant-level edge cases.
    run_cfg(9, 3, 6, 7, 32);
    run_cfg(9, 0, 0, 0, 22);
    run_cfg(9, 12, 0, 0, 22);
    run_cfg(0, 1, 0, 0, 8);

    repeat (6) begin
      p  = int'($urandom_range(0, 12));
      d  = int'($urandom_range(0, 15));
      wk = int'($urandom_range(0, p + 3));
      d2 = int'($urandom_range(0, 15));
      run_cfg(p, d, wk, d2, 3 * (p + 1) + 2);
    end

`ifdef PWM_IRQ_EN
    cycle(1'b1, 1'b1, 1'b0, A_CTRL, 32'h100);
    cycle(1'b1, 1'b1, 1'b0, A_PER, 32'd4);
    cycle(1'b1, 1'b1, 1'b0, A_DUTY, 32'd2);
    cycle(1'b1, 1'b1, 1'b0, A_CTRL, 32'h201);
    sts = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 9 || k == 16) cycle(1'b1, 1'b1, 1'b0, A_CTRL, 32'h301);
      else                   cycle(1'b0, 1'b0, 1'b0, A_CNT, 32'h0);
      w = (k >= 2) && ((k - 2) % 5 == 4);
      if (w) sts = 1'b1;
      else if (k == 9 || k == 16) sts = 1'b0;
      chk("irq_wrap_status", 32'(irq), 32'(sts));
    end
    cycle(1'b1, 1'b0, 1'b1, A_CTRL, 32'h0);
    chk("ctrl_read_irq", bRData, 32'h301);
`endif

    // Reset asserted in the middle of a clock period while the output is high.
    cycle(1'b1, 1'b1, 1'b0, A_CTRL, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, A_PER, 32'd3);
    cycle(1'b1, 1'b1, 1'b0, A_DUTY, 32'd9);
`ifdef PWM_IRQ_EN
    cycle(1'b1, 1'b1, 1'b0, A_CTRL, 32'h201);
`else
    cycle(1'b1, 1'b1, 1'b0, A_CTRL, 32'h1);
`endif
    repeat (8) cycle(1'b0, 1'b0, 1'b0, A_CNT, 32'h0);
    chk("pwm_high_before_reset", 32'(pwm_out), 32'h1);
`ifdef PWM_IRQ_EN
    chk("irq_high_before_reset", 32'(irq), 32'h1);
`endif
    cycle(1'b1, 1'b0, 1'b1, A_PER, 32'h0);
    #3 rst = 1'b1;
    #1;
    chk("async_reset_pwm", 32'(pwm_out), 32'h0);
    chk("async_reset_irq", 32'(irq), 32'h0);
    chk("async_reset_rdata", bRData, 32'h0);
    #2 rst = 1'b0;
    cycle(1'b1, 1'b0, 1'b1, A_CTRL, 32'h0);
    chk("ctrl_after_reset", bRData, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, A_PER, 32'h0);
    chk("period_after_reset", bRData, 32'h0);
    chk("pwm_after_reset", 32'(pwm_out), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
